// File: rtl/pipe_ctrl_hdu.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_hdu
//
// Pipelined MIPS control unit with load-use hazard detection. Decodes the
// ID-stage opcode into a control bundle and carries it through the ID/EX,
// EX/MEM and MEM/WB control registers. It also steers the PC and the IF/ID
// register for stalls, flushes and memory freezes.
//
// Ports
//   clk, resetn             clock (rising edge), synchronous active-low reset
//   idValid, idOpcode       IF/ID holds a real instruction, and its opcode
//   idRs, idRt              ID-stage source register fields
//   idRtDst                 ID-stage load destination (becomes exRt)
//   memReady                0 = data memory busy, freeze the whole pipeline
//   branchTaken             EX-stage branch resolved taken
//   pcWrite, ifIdWrite      PC / IF/ID load enables (combinational)
//   ifIdFlush               clear IF/ID to a bubble (combinational)
//   ex_*                    ID/EX control register outputs
//   mem_*                   EX/MEM control register outputs
//   wb_*                    MEM/WB control register outputs
//   illegalOp               registered pulse: an illegal opcode entered ID/EX
//   stallCnt, flushCnt      saturating performance counters
// ---------------------------------------------------------------------------
module pipe_ctrl_hdu #(
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16,
  parameter int EN_JUMP = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             idValid,
  input  logic [OPC_W-1:0] idOpcode,
  input  logic [RA_W-1:0]  idRs,
  input  logic [RA_W-1:0]  idRt,
  input  logic [RA_W-1:0]  idRtDst,
  input  logic             memReady,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic [1:0]       ex_aluOp,
  output logic             ex_aluSrc,
  output logic             ex_regDest,
  output logic             ex_branch,
  output logic             ex_bne,
  output logic             mem_memRead,
  output logic             mem_memWrite,
  output logic             wb_memtoReg,
  output logic             wb_regWrite,
  output logic             illegalOp,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(35);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(43);

  // ---- ID-stage decode ----------------------------------------------------
  logic [1:0] dAluOp;
  logic       dAluSrc, dBranch, dBne, dMemRead, dMemWrite;
  logic       dMemtoReg, dRegDest, dRegWrite;
  logic       isJump, isLegal;

  always_comb begin
    dAluOp    = 2'b00;
    dAluSrc   = 1'b0;
    dBranch   = 1'b0;
    dBne      = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dMemtoReg = 1'b0;
    dRegDest  = 1'b0;
    dRegWrite = 1'b0;
    isJump    = 1'b0;
    isLegal   = 1'b0;
    if (idValid) begin
      case (idOpcode)
        OP_RTYPE: begin
          dAluOp    = 2'b10;
          dRegDest  = 1'b1;
          dRegWrite = 1'b1;
          isLegal   = 1'b1;
        end
        OP_ADDI: begin
          dAluSrc   = 1'b1;
          dRegWrite = 1'b1;
          isLegal   = 1'b1;
        end
        OP_LW: begin
          dAluSrc   = 1'b1;
          dMemRead  = 1'b1;
          dMemtoReg = 1'b1;
          dRegWrite = 1'b1;
          isLegal   = 1'b1;
        end
        OP_SW: begin
          dAluSrc   = 1'b1;
          dMemWrite = 1'b1;
          isLegal   = 1'b1;
        end
        OP_BEQ: begin
          dAluOp  = 2'b01;
          dBranch = 1'b1;
          isLegal = 1'b1;
        end
        OP_BNE: begin
          dAluOp  = 2'b01;
          dBranch = 1'b1;
          dBne    = 1'b1;
          isLegal = 1'b1;
        end
        OP_J: begin
          // A jump carries an all-zero bundle; its effect is the IF/ID flush.
          if (EN_JUMP != 0) begin
            isJump  = 1'b1;
            isLegal = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- pipeline control registers ----------------------------------------
  logic [RA_W-1:0] exRt;
  logic            exMemRead, exMemWrite, exMemtoReg, exRegWrite;
  logic            memMemtoReg, memRegWrite;

  // ---- load-use hazard ----------------------------------------------------
  logic usesRt, hz;

  assign usesRt = (idOpcode == OP_RTYPE) || (idOpcode == OP_BEQ) ||
                  (idOpcode == OP_BNE)   || (idOpcode == OP_SW);

  assign hz = exMemRead && (exRt != '0) &&
              ((exRt == idRs) || ((exRt == idRt) && usesRt));

  // ---- event resolution: freeze > flush > stall > normal -------------------
  logic flushAct, stallAct, jumpAct, bubbleIdEx;

  assign flushAct   = memReady && branchTaken;
  assign stallAct   = memReady && !branchTaken && hz;
  // A jump stalled behind a load-use hazard is simply re-decoded next cycle.
  assign jumpAct    = memReady && !branchTaken && !hz && isJump;
  assign bubbleIdEx = branchTaken || hz;

  always_comb begin
    pcWrite   = 1'b0;
    ifIdWrite = 1'b0;
    ifIdFlush = 1'b0;
    if (resetn && memReady) begin
      if (branchTaken) begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b1;
      end else if (!hz) begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = isJump;
      end
    end
  end

  // ---- stage registers and counters ---------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_aluOp     <= 2'b00;
      ex_aluSrc    <= 1'b0;
      ex_regDest   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_bne       <= 1'b0;
      exMemRead    <= 1'b0;
      exMemWrite   <= 1'b0;
      exMemtoReg   <= 1'b0;
      exRegWrite   <= 1'b0;
      exRt         <= '0;
      mem_memRead  <= 1'b0;
      mem_memWrite <= 1'b0;
      memMemtoReg  <= 1'b0;
      memRegWrite  <= 1'b0;
      wb_memtoReg  <= 1'b0;
      wb_regWrite  <= 1'b0;
      illegalOp    <= 1'b0;
      stallCnt     <= '0;
      flushCnt     <= '0;
    end else if (memReady) begin
      // MEM/WB and EX/MEM always advance when memory is ready.
      wb_memtoReg  <= memMemtoReg;
      wb_regWrite  <= memRegWrite;
      mem_memRead  <= exMemRead;
      mem_memWrite <= exMemWrite;
      memMemtoReg  <= exMemtoReg;
      memRegWrite  <= exRegWrite;

      if (bubbleIdEx) begin
        ex_aluOp   <= 2'b00;
        ex_aluSrc  <= 1'b0;
        ex_regDest <= 1'b0;
        ex_branch  <= 1'b0;
        ex_bne     <= 1'b0;
        exMemRead  <= 1'b0;
        exMemWrite <= 1'b0;
        exMemtoReg <= 1'b0;
        exRegWrite <= 1'b0;
        exRt       <= '0;
        illegalOp  <= 1'b0;
      end else begin
        ex_aluOp   <= dAluOp;
        ex_aluSrc  <= dAluSrc;
        ex_regDest <= dRegDest;
        ex_branch  <= dBranch;
        ex_bne     <= dBne;
        exMemRead  <= dMemRead;
        exMemWrite <= dMemWrite;
        exMemtoReg <= dMemtoReg;
        exRegWrite <= dRegWrite;
        exRt       <= idRtDst;
        illegalOp  <= idValid && !isLegal;
      end

      if (stallAct && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if ((flushAct || jumpAct) && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

endmodule
